mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single SRAM-like downstream port of the AXI bridge between the instruction-fetch requester and the data-memory requester of the MIPS core.
- One transaction is in flight at a time.
- Data has priority over instruction, with a starvation counter that guarantees fetch progress.
- Sits between the fetch/mem stages and the sram-to-AXI bridge.

Parameters:
STARVE_LIMIT, 4, consecutive data grants issued while inst_req is pending before inst wins a tie.
CNT_W, 3, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
clk in 1 system clock, rising edge
rst in 1 synchronous reset, active-high
inst_req in 1 fetch request
inst_addr in 32 fetch byte address
inst_addr_ok out 1 fetch address accepted
inst_data_ok out 1 fetch data valid
inst_rdata out 32 fetch read data
data_req in 1 data request
data_wr in 1 1=store, 0=load
data_size in 2 0=byte, 1=half, 2=word
data_addr in 32 data byte address
data_wdata in 32 store data
data_addr_ok out 1 data address accepted
data_data_ok out 1 data read valid / write done
data_rdata out 32 load data
mem_req out 1 downstream request
mem_wr out 1 downstream write
mem_size out 2 downstream size
mem_addr out 32 downstream address
mem_wdata out 32 downstream write data
mem_addr_ok in 1 downstream address accepted
mem_data_ok in 1 downstream data/response
mem_rdata in 32 downstream read data

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset rst.
- States: IDLE, ADDR, WAIT. Registered owner bit: 0=inst, 1=data. Registered starve_cnt.
- Reset state: IDLE, owner=0, starve_cnt=0. All outputs are 0 while in IDLE (rdata buses 0).
- IDLE arbitration: evaluated every cycle.
  - If data_req && !(inst_req && starve_cnt==STARVE_LIMIT): owner<=1. If inst_req, starve_cnt<=min(starve_cnt+1, STARVE_LIMIT).
  - Else if inst_req: owner<=0, starve_cnt<=0.
  - On any grant, go to ADDR next cycle. With no request, stay in IDLE.
- ADDR state:
  - mem_req = owner's req. mem_wr, mem_size and mem_addr/mem_wdata are muxed from the owner. An inst owner drives wr=0, size=2, wdata=0.
  - The owner's addr_ok equals mem_addr_ok & mem_req.
  - On mem_addr_ok & mem_req, go to WAIT.
  - If the owner's req is low, return to IDLE (abandoned, no downstream effect).
- WAIT state:
  - mem_req=0.
  - The owner's data_ok equals mem_data_ok, and the owner's rdata equals mem_rdata (combinational pass-through).
  - On mem_data_ok, go to IDLE.
- Non-owner: addr_ok, data_ok and rdata are 0 in every state.
- Latency: from req high in IDLE, mem_req is high the next cycle. From data_ok, there is at least 1 IDLE cycle before the next mem_req. Back-to-back transactions therefore cost ≥3 cycles each.
- mem_data_ok seen in IDLE or ADDR is ignored (stale response after reset).
- Simultaneous mem_addr_ok and mem_data_ok in ADDR: only the addr_ok is honoured.
- Requesters must hold addr/wr/size/wdata stable while req is high and addr_ok is not yet seen. The arbiter does not latch them.
- Reset asserted mid-transaction: the block returns to IDLE on the next edge, and the counter clears.

Decomposition:
- Shared package: state encodings (IDLE/ADDR/WAIT), OWNER_INST/OWNER_DATA, SIZE_BYTE/HALF/WORD constants.
- One natural sub-module, arb_starve_sel: holds starve_cnt and the grant decision, with inputs inst_req, data_req, grant_en and outputs grant_valid, grant_owner.

Test Plan:
1. inst_req only, addr 0xbfc00000. mem_req rises 1 cycle later. addr_ok after 2 cycles, data_ok with mem_rdata 0x3c1d0000 → inst_data_ok=1 and inst_rdata=0x3c1d0000 in the same cycle; returns to IDLE.
2. inst_req and data_req both high, store word 0xdeadbeef to 0x80001000 → data is granted first with mem_wr=1, mem_size=2. Inst is granted only after data_data_ok.
3. inst_req held high while data_req is high continuously → after 4 data grants, the 5th arbitration grants inst; starve_cnt then returns to 0.
4. Owner drops req in ADDR before mem_addr_ok → returns to IDLE, no addr_ok or data_ok is forwarded, and the other pending requester is granted next.
5. rst pulsed while in WAIT, then mem_data_ok arrives in the following cycle → no data_ok is forwarded, and all outputs are 0.
6. mem_addr_ok and mem_data_ok both asserted in ADDR → transition to WAIT, data_ok is not forwarded that cycle, and completion occurs on the next mem_data_ok.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_starve_sel.sv
// Grant decision: data wins unless fetch has waited STARVE_LIMIT data grants.
// Latency: combinational grant; the starvation counter updates on the granting edge.
// Backpressure: the decision is only committed while grant_en is high.
module arb_starve_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inst_req,
    input  logic data_req,
    input  logic grant_en,
    output logic grant_valid,
    output logic grant_owner
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             data_wins;

    assign data_wins   = data_req && !(inst_req && (starve_cnt == LIMIT));
    assign grant_valid = data_req || inst_req;
    assign grant_owner = data_wins ? OWNER_DATA : OWNER_INST;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_en && grant_valid) begin
            if (data_wins) begin
                // Only count data grants that actually made fetch wait; saturate.
                if (inst_req && (starve_cnt != LIMIT)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between fetch and data requesters, one transaction in flight.
// Latency: mem_req one cycle after a grant in IDLE; >=3 cycles per back-to-back transaction.
// Backpressure: owner waits in ADDR for mem_addr_ok and in WAIT for mem_data_ok.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    arb_state_t state;
    logic       owner;
    logic       grant_valid;
    logic       grant_owner;
    logic       owner_req;
    logic       in_addr;
    logic       in_wait;
    logic       addr_ok;

    arb_starve_sel #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_sel (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .data_req    (data_req),
        .grant_en    (state == ST_IDLE),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign owner_req = (owner == OWNER_DATA) ? data_req : inst_req;
    assign in_addr   = (state == ST_ADDR);
    assign in_wait   = (state == ST_WAIT);
    assign addr_ok   = in_addr && owner_req && mem_addr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            owner <= OWNER_INST;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner <= grant_owner;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // A dropped request is abandoned; a concurrent mem_data_ok is ignored.
                    if (!owner_req) begin
                        state <= ST_IDLE;
                    end else if (mem_addr_ok) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_data_ok) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = SIZE_BYTE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (in_addr) begin
            mem_req = owner_req;
            if (owner == OWNER_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_size  = SIZE_WORD;
                mem_addr  = inst_addr;
            end
        end
    end

    always_comb begin
        inst_addr_ok = addr_ok && (owner == OWNER_INST);
        data_addr_ok = addr_ok && (owner == OWNER_DATA);
        inst_data_ok = in_wait && mem_data_ok && (owner == OWNER_INST);
        data_data_ok = in_wait && mem_data_ok && (owner == OWNER_DATA);
        inst_rdata   = (in_wait && (owner == OWNER_INST)) ? mem_rdata : '0;
        data_rdata   = (in_wait && (owner == OWNER_DATA)) ? mem_rdata : '0;
    end

endmodule
